dram_pipe: RTL and testbench
============================

// Module: dram_pipe
// PURPOSE
//  Parametrised word-addressed DRAM behavioural model for the lenet bench and the FPGA memory shim.
//  Replaces the fixed-latency dram model: configurable width, depth and read latency,
//  pipelined reads, and ready back-pressure.
//  Sits between the lenet dram_en_rd/dram_en_wr ports and the bench pattern loaders.
//  Has one synchronous write port and one synchronous read port. Read data returns in order.
// PARAMETERS
//  DATA_WIDTH      32      word width in bits
//  ADDR_WIDTH      18      address width in bits
//  DEPTH           262144  number of implemented words; must be <= 2**ADDR_WIDTH
//  RD_LATENCY      4       cycles from read acceptance to valid; must be >= 1
//  REFRESH_PERIOD  1024    cycles between refresh windows (DRAM_REFRESH_EN only)
//  REFRESH_CYCLES  8       length of one refresh window (DRAM_REFRESH_EN only)
// PORTS
//  clk       in   1           clock, all logic on the rising edge
//  srst      in   1           synchronous reset, active-high
//  en_wr     in   1           write request
//  addr_wr   in   ADDR_WIDTH  write address
//  data_in   in   DATA_WIDTH  write data
//  wr_rdy    out  1           write accepted when en_wr && wr_rdy
//  en_rd     in   1           read request
//  addr_rd   in   ADDR_WIDTH  read address
//  rd_rdy    out  1           read accepted when en_rd && rd_rdy
//  valid     out  1           data_out is valid (one-cycle strobe per accepted read)
//  data_out  out  DATA_WIDTH  read data
//  rd_err    out  1           qualifies valid: the read address was >= DEPTH
// BEHAVIOUR
//  - Reset (srst=1 at an edge):
//    - valid=0, rd_err=0, data_out=0. All in-flight reads are discarded.
//    - Refresh counter is cleared to 0.
//    - Memory contents are NOT cleared.
//    - wr_rdy/rd_rdy are 1 at reset and whenever not in a refresh window.
//  - Write: on an edge with en_wr && wr_rdy && addr_wr<DEPTH, mem[addr_wr] <= data_in.
//    A write with addr_wr>=DEPTH is dropped silently.
//  - Read: on an edge with en_rd && rd_rdy, {addr_rd, err} enters a RD_LATENCY-deep shift pipeline.
//    - Data is sampled from the array at the acceptance edge.
//    - valid=1 for exactly one cycle, RD_LATENCY cycles after acceptance.
//      With RD_LATENCY=1, valid is high in the cycle right after the accepting edge.
//  - Throughput: one read and one write may be accepted every cycle.
//    Back-to-back reads produce back-to-back valid strobes, in request order.
//  - Write/read collision: same edge, same address, both accepted -> write-first.
//    The read returns the new data_in.
//  - Out-of-range read (addr_rd>=DEPTH): still produces a valid strobe, with data_out=0 and rd_err=1.
//  - data_out/rd_err hold their last value when valid=0. data_out is 0 after reset until the first valid.
//  - Request held while rdy=0 is not accepted. The master must hold en/addr/data until rdy=1;
//    the block keeps no record of refused requests.
//  - Reset mid-operation: srst wins over any simultaneous request. That request is not accepted,
//    and no valid appears for reads accepted before the reset.
// CONFIGURATION
//  DRAM_REFRESH_EN defined:
//    - Free-running counter 0..REFRESH_PERIOD+REFRESH_CYCLES-1, cleared by srst.
//    - While counter >= REFRESH_PERIOD: wr_rdy=0 and rd_rdy=0, so no new requests are accepted.
//      With the defaults this is cycles 1024..1031 after reset.
//    - Reads already in the pipeline still complete on schedule.
//  DRAM_REFRESH_EN undefined:
//    - No counter is built. wr_rdy=rd_rdy=1 constantly (except during srst, where requests are ignored).
// TESTING
//  1. Write 0xDEADBEEF @0x10, then read 0x10 (RD_LATENCY=4)
//     -> valid exactly 4 cycles after acceptance, data_out=0xDEADBEEF, rd_err=0.
//  2. Reads of 0..7 on 8 consecutive cycles (mem[i]=i+0x100)
//     -> 8 consecutive valid cycles, data 0x100..0x107 in order.
//  3. mem[0x20]=0x1; same edge write 0x2 @0x20 and read 0x20 -> returned data 0x2.
//  4. DEPTH=1000: read 1000 -> valid, data_out=0, rd_err=1.
//     Write 0x55 @1000, then read 999 -> unchanged value.
//  5. 3 reads in flight, assert srst one cycle -> valid stays 0 for 8 cycles, data_out=0.
//     A re-read after reset returns the pre-reset contents.
//  6. DRAM_REFRESH_EN, REFRESH_PERIOD=64, REFRESH_CYCLES=8:
//     -> rd_rdy=0 during cycles 64..71 after reset.
//     Held read at cycle 65 is accepted at cycle 72, and valid follows RD_LATENCY later.

Source files
------------

// File: rtl/dram_pipe.sv
`default_nettype none
// ============================================================================
// Module      : dram_pipe
// Description : Word-addressed DRAM model: one write and one read port,
//               pipelined in-order reads of configurable latency, ready
//               back-pressure. Optional refresh windows via DRAM_REFRESH_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module dram_pipe #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 18,
    parameter int DEPTH          = 262144,
    parameter int RD_LATENCY     = 4,
    parameter int REFRESH_PERIOD = 1024,
    parameter int REFRESH_CYCLES = 8
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic                  en_wr,
    input  logic [ADDR_WIDTH-1:0] addr_wr,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  wr_rdy,
    input  logic                  en_rd,
    input  logic [ADDR_WIDTH-1:0] addr_rd,
    output logic                  rd_rdy,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  rd_err
);

    localparam int                  c_IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] c_DEPTH = (ADDR_WIDTH + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];
    logic                  w_rdy;

`ifdef DRAM_REFRESH_EN
    localparam int c_REF_TOTAL = REFRESH_PERIOD + REFRESH_CYCLES;
    localparam int c_REF_W     = (c_REF_TOTAL > 1) ? $clog2(c_REF_TOTAL) : 1;

    logic [c_REF_W-1:0] r_ref_cnt_q;
    logic [c_REF_W-1:0] w_ref_cnt_d;

    always_comb begin
        w_ref_cnt_d = r_ref_cnt_q + c_REF_W'(1);
        if (r_ref_cnt_q == c_REF_W'(c_REF_TOTAL - 1)) begin
            w_ref_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            r_ref_cnt_q <= '0;
        end else begin
            r_ref_cnt_q <= w_ref_cnt_d;
        end
    end

    // The tail of each counter period is the refresh window.
    assign w_rdy = (r_ref_cnt_q < c_REF_W'(REFRESH_PERIOD));
`else
    assign w_rdy = 1'b1;
`endif

    assign wr_rdy = w_rdy;
    assign rd_rdy = w_rdy;

    logic                  w_wr_acc;
    logic                  w_rd_acc;
    logic                  w_wr_in_range;
    logic                  w_rd_in_range;
    logic                  w_wr_do;
    logic                  w_rd_err;
    logic [DATA_WIDTH-1:0] w_rd_data;

    assign w_wr_acc      = en_wr && w_rdy && !srst;
    assign w_rd_acc      = en_rd && w_rdy && !srst;
    assign w_wr_in_range = ({1'b0, addr_wr} < c_DEPTH);
    assign w_rd_in_range = ({1'b0, addr_rd} < c_DEPTH);
    assign w_wr_do       = w_wr_acc && w_wr_in_range;
    assign w_rd_err      = !w_rd_in_range;

    // Write-first: a same-edge write to the read address forwards data_in.
    always_comb begin
        w_rd_data = '0;
        if (w_rd_in_range) begin
            if (w_wr_do && (addr_wr == addr_rd)) begin
                w_rd_data = data_in;
            end else begin
                w_rd_data = r_mem[addr_rd[c_IDX_W-1:0]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_do) begin
            r_mem[addr_wr[c_IDX_W-1:0]] <= data_in;
        end
    end

    // Read pipeline: stage 0 loads at acceptance, the last stage drives the outputs.
    logic [RD_LATENCY-1:0]                 r_pv_q,    w_pv_d;
    logic [RD_LATENCY-1:0]                 r_perr_q,  w_perr_d;
    logic [RD_LATENCY-1:0][DATA_WIDTH-1:0] r_pdata_q, w_pdata_d;

    logic [RD_LATENCY:0]                   w_chain_v;
    logic [RD_LATENCY:0]                   w_chain_err;
    logic [RD_LATENCY:0][DATA_WIDTH-1:0]   w_chain_data;

    assign w_chain_v    = {r_pv_q, w_rd_acc};
    assign w_chain_err  = {r_perr_q, w_rd_err};
    assign w_chain_data = {r_pdata_q, w_rd_data};

    // Payloads only move with a valid token so the last stage holds between strobes.
    always_comb begin
        w_pv_d    = w_chain_v[RD_LATENCY-1:0];
        w_perr_d  = r_perr_q;
        w_pdata_d = r_pdata_q;
        for (int i = 0; i < RD_LATENCY; i++) begin
            if (w_chain_v[i]) begin
                w_perr_d[i]  = w_chain_err[i];
                w_pdata_d[i] = w_chain_data[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            r_pv_q    <= '0;
            r_perr_q  <= '0;
            r_pdata_q <= '0;
        end else begin
            r_pv_q    <= w_pv_d;
            r_perr_q  <= w_perr_d;
            r_pdata_q <= w_pdata_d;
        end
    end

    assign valid    = r_pv_q[RD_LATENCY-1];
    assign rd_err   = r_perr_q[RD_LATENCY-1];
    assign data_out = r_pdata_q[RD_LATENCY-1];

endmodule
`default_nettype wire

// File: tb/tb_dram_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_dram_pipe
// Description : Self-checking bench for dram_pipe against a queue-based
//               reference model; refresh checks follow DRAM_REFRESH_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dram_pipe;

    localparam int DW    = 32;
    localparam int AW    = 18;
    localparam int DEPTH = 1000;
    localparam int LAT   = 4;
    localparam int RP    = 64;
    localparam int RC    = 8;
`ifdef DRAM_REFRESH_EN
    localparam bit c_REF_EN = 1'b1;
`else
    localparam bit c_REF_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          srst;
    logic          en_wr;
    logic [AW-1:0] addr_wr;
    logic [DW-1:0] data_in;
    logic          wr_rdy;
    logic          en_rd;
    logic [AW-1:0] addr_rd;
    logic          rd_rdy;
    logic          valid;
    logic [DW-1:0] data_out;
    logic          rd_err;

    always #5 clk = ~clk;

    dram_pipe #(
        .DATA_WIDTH    (DW),
        .ADDR_WIDTH    (AW),
        .DEPTH         (DEPTH),
        .RD_LATENCY    (LAT),
        .REFRESH_PERIOD(RP),
        .REFRESH_CYCLES(RC)
    ) u_dut (
        .clk     (clk),
        .srst    (srst),
        .en_wr   (en_wr),
        .addr_wr (addr_wr),
        .data_in (data_in),
        .wr_rdy  (wr_rdy),
        .en_rd   (en_rd),
        .addr_rd (addr_rd),
        .rd_rdy  (rd_rdy),
        .valid   (valid),
        .data_out(data_out),
        .rd_err  (rd_err)
    );

    typedef struct {
        int            due;
        logic [DW-1:0] d;
        logic          e;
    } rsp_t;

    rsp_t          exp_q[$];
    logic [DW-1:0] mem_m [0:DEPTH-1];
    int            edge_n   = 0;
    int            rst_edge = 0;
    logic [DW-1:0] last_d   = '0;
    logic          last_e   = 1'b0;
    bit            wr_took;
    bit            rd_took;
    int            n_cmp    = 0;
    int            n_bad    = 0;

    // cyc counts clock periods since the last reset edge, starting at 0.
    function automatic bit model_rdy(int cyc);
        return !c_REF_EN || ((cyc % (RP + RC)) < RP);
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, edge_n);
        end
    endtask

    task automatic tick();
        bit   rdy;
        bit   ev;
        rsp_t r;
        @(posedge clk);
        edge_n++;
        wr_took = 1'b0;
        rd_took = 1'b0;
        if (srst) begin
            exp_q.delete();
            last_d   = '0;
            last_e   = 1'b0;
            rst_edge = edge_n;
        end else begin
            rdy = model_rdy(edge_n - rst_edge - 1);
            if (en_wr && rdy) begin
                wr_took = 1'b1;
                if (int'(addr_wr) < DEPTH) mem_m[int'(addr_wr)] = data_in;
            end
            if (en_rd && rdy) begin
                rd_took = 1'b1;
                r.due   = edge_n + LAT - 1;
                r.e     = (int'(addr_rd) >= DEPTH);
                r.d     = r.e ? '0 : mem_m[int'(addr_rd)];
                exp_q.push_back(r);
            end
        end
        @(negedge clk);
        ev = (exp_q.size() > 0) && (exp_q[0].due == edge_n);
        if (ev) begin
            last_d = exp_q[0].d;
            last_e = exp_q[0].e;
            void'(exp_q.pop_front());
        end
        chk("valid", 64'(valid), 64'(ev));
        chk("data_out", 64'(data_out), 64'(last_d));
        chk("rd_err", 64'(rd_err), 64'(last_e));
        chk("rd_rdy", 64'(rd_rdy), 64'(model_rdy(edge_n - rst_edge)));
        chk("wr_rdy", 64'(wr_rdy), 64'(model_rdy(edge_n - rst_edge)));
    endtask

    // Holds the request until accepted; leaves it asserted for back-to-back use.
    task automatic req(bit w, int wa, logic [DW-1:0] wd, bit r, int ra);
        en_wr   = w;
        addr_wr = AW'(wa);
        data_in = wd;
        en_rd   = r;
        addr_rd = AW'(ra);
        for (int k = 0; k < 2 * RC + 4; k++) begin
            tick();
            if ((!w || wr_took) && (!r || rd_took)) break;
        end
        if ((w && !wr_took) || (r && !rd_took)) begin
            n_cmp++;
            n_bad++;
            $error("FAIL accept_timeout: observed not accepted expected accepted (edge %0d)", edge_n);
        end
    endtask

    task automatic idle(int n);
        en_wr = 1'b0;
        en_rd = 1'b0;
        repeat (n) tick();
    endtask

    initial begin
        srst    = 1'b1;
        en_wr   = 1'b0;
        en_rd   = 1'b0;
        addr_wr = '0;
        addr_rd = '0;
        data_in = '0;
        repeat (2) tick();
        srst = 1'b0;
        idle(1);

        for (int i = 0; i < DEPTH; i++) begin
            logic [DW-1:0] v;
            v = $urandom;
            if (i < 8) v = DW'(i + 'h100);
            if (i == 'h20) v = 'h1;
            req(1'b1, i, v, 1'b0, 0);
        end
        idle(2);

        req(1'b1, 'h10, 32'hDEADBEEF, 1'b0, 0);
        req(1'b0, 0, '0, 1'b1, 'h10);
        idle(LAT + 2);

        for (int i = 0; i < 8; i++) req(1'b0, 0, '0, 1'b1, i);
        idle(LAT + 2);

        req(1'b1, 'h20, 32'h2, 1'b1, 'h20);
        idle(LAT + 2);

        req(1'b0, 0, '0, 1'b1, DEPTH);
        idle(LAT + 1);
        req(1'b1, DEPTH, 32'h55, 1'b0, 0);
        req(1'b0, 0, '0, 1'b1, DEPTH - 1);
        idle(LAT + 2);

        for (int i = 1; i <= 3; i++) req(1'b0, 0, '0, 1'b1, i);
        en_rd = 1'b0;
        srst  = 1'b1;
        tick();
        srst  = 1'b0;
        idle(8);
        for (int i = 1; i <= 3; i++) req(1'b0, 0, '0, 1'b1, i);
        idle(LAT + 2);

        for (int n = 0; n < 400; n++) begin
            srst    = ($urandom_range(0, 49) == 0);
            en_wr   = $urandom_range(0, 1);
            en_rd   = $urandom_range(0, 1);
            addr_wr = AW'($urandom_range(0, 1023));
            addr_rd = ($urandom_range(0, 3) == 0) ? addr_wr : AW'($urandom_range(0, 1023));
            data_in = $urandom;
            tick();
        end
        srst = 1'b0;
        idle(LAT + 2);

        srst = 1'b1;
        tick();
        srst = 1'b0;
        idle(65);
        req(1'b0, 0, '0, 1'b1, 5);
        idle(LAT + 2);
        for (int i = 0; i < 4; i++) req(1'b0, 0, '0, 1'b1, $urandom_range(0, DEPTH - 1));
        idle(RP + RC + LAT);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
